// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: walks the FIR tap memory read address once per accepted
// sample and grants SPI coefficient writes onto the memory write port between
// sequences.
// Optional build macro: TAP_SEQ_REVERSE_EN (walk read addresses high to low).
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 32,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              cfg_wr_req,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_wr_ack,
  output logic              cfg_wr_err,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_value,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_index,
  output logic              tap_first,
  output logic              tap_last,
  output logic              seq_done,
  output logic              overrun,
  input  logic              overrun_clr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, WRITE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]   NUM_TAPS_W = (ADDR_W + 1)'(NUM_TAPS);

  state_t state, state_nxt;

  logic              in_range;
  logic              tv_nxt, first_nxt, last_nxt, done_nxt;
  logic              ack_nxt, err_nxt, load_nxt;
  logic [ADDR_W-1:0] idx_nxt, ra_nxt, wa_nxt;
  logic [DATA_W-1:0] wv_nxt;

  assign in_range     = {1'b0, cfg_wr_addr} < NUM_TAPS_W;
  assign sample_ready = (state == IDLE);

  // Tap ordinal to physical read address.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] idx);
`ifdef TAP_SEQ_REVERSE_EN
    return LAST_IDX - idx;
`else
    return idx;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a sample beats a pending config write; writes only start from IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_valid)    state_nxt = RUN;
               else if (cfg_wr_req) state_nxt = WRITE;
      RUN:     if (tap_index == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: values the output registers take on the coming edge.
  always_comb begin
    tv_nxt    = 1'b0;
    idx_nxt   = '0;
    first_nxt = 1'b0;
    last_nxt  = 1'b0;
    done_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    load_nxt  = 1'b0;
    ra_nxt    = '0;
    wa_nxt    = mem_write_address;
    wv_nxt    = mem_write_value;
    unique case (state)
      IDLE: begin
        if (sample_valid) begin
          tv_nxt    = 1'b1;
          first_nxt = 1'b1;
          last_nxt  = (NUM_TAPS == 1);
          ra_nxt    = rd_addr('0);
        end else if (cfg_wr_req) begin
          ack_nxt = 1'b1;
          if (in_range) begin
            load_nxt = 1'b1;
            wa_nxt   = cfg_wr_addr;
            wv_nxt   = cfg_wr_data;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (tap_index == LAST_IDX) begin
          done_nxt = 1'b1;
          idx_nxt  = tap_index;
        end else begin
          tv_nxt   = 1'b1;
          idx_nxt  = tap_index + 1'b1;
          last_nxt = ((tap_index + 1'b1) == LAST_IDX);
          ra_nxt   = rd_addr(tap_index + 1'b1);
        end
      end
      default: ;
    endcase
  end

  // Output registers; async reset aborts any run or write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_valid         <= 1'b0;
      tap_index         <= '0;
      tap_first         <= 1'b0;
      tap_last          <= 1'b0;
      seq_done          <= 1'b0;
      cfg_wr_ack        <= 1'b0;
      cfg_wr_err        <= 1'b0;
      mem_load          <= 1'b0;
      mem_write_address <= '0;
      mem_write_value   <= '0;
      mem_read_address  <= '0;
    end else begin
      tap_valid         <= tv_nxt;
      tap_index         <= idx_nxt;
      tap_first         <= first_nxt;
      tap_last          <= last_nxt;
      seq_done          <= done_nxt;
      cfg_wr_ack        <= ack_nxt;
      cfg_wr_err        <= err_nxt;
      mem_load          <= load_nxt;
      mem_write_address <= wa_nxt;
      mem_write_value   <= wv_nxt;
      mem_read_address  <= ra_nxt;
    end
  end

  // Sticky overrun: a dropped sample sets it, and setting beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= (sample_valid && (state != IDLE)) || (overrun && !overrun_clr);
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed table, hand-written corner sequences and
// random traffic against a cycle-count reference model.
module tb_fir_tap_sequencer;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0, sample_ready;
  logic        cfg_wr_req = 1'b0;
  logic [7:0]  cfg_wr_addr = '0;
  logic [11:0] cfg_wr_data = '0;
  logic        cfg_wr_ack, cfg_wr_err, mem_load;
  logic [7:0]  mem_write_address, mem_read_address, tap_index;
  logic [11:0] mem_write_value;
  logic        tap_valid, tap_first, tap_last, seq_done, overrun;
  logic        overrun_clr = 1'b0;

  fir_tap_sequencer #(.NUM_TAPS(N), .ADDR_W(8), .DATA_W(12)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ack(cfg_wr_ack), .cfg_wr_err(cfg_wr_err),
    .mem_load(mem_load), .mem_write_address(mem_write_address),
    .mem_write_value(mem_write_value), .mem_read_address(mem_read_address),
    .tap_valid(tap_valid), .tap_index(tap_index), .tap_first(tap_first),
    .tap_last(tap_last), .seq_done(seq_done), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: cycles since the last accepted sample plus write bookkeeping.
  int          m_since;
  bit          m_wr, m_err, m_load, m_ovr;
  logic [7:0]  m_wa;
  logic [11:0] m_wv;

  typedef struct {
    bit sv; bit req; logic [7:0] addr; logic [11:0] data; bit clr;
    bit e_ready; bit e_ack; bit e_err; bit e_load;
    logic [7:0] e_wa; logic [11:0] e_wv; bit e_tv; bit e_ovr;
  } vec_t;
  vec_t tbl[11];

  task automatic model_reset();
    m_since = N + 2; m_wr = 0; m_err = 0; m_load = 0; m_ovr = 0;
    m_wa = '0; m_wv = '0;
  endtask

  task automatic check(input string tag, input logic [44:0] act, input logic [44:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit tv;
    logic [7:0] idx, ra;
    logic [44:0] exp, act;
    tv  = (m_since >= 1) && (m_since <= N);
    idx = tv ? 8'(m_since - 1) : 8'd0;
`ifdef TAP_SEQ_REVERSE_EN
    ra  = tv ? 8'(N - 1) - idx : 8'd0;
`else
    ra  = idx;
`endif
    exp = {(m_since >= N + 2) && !m_wr, tv, idx, tv && m_since == 1, tv && m_since == N,
           m_since == N + 1, m_wr, m_err, m_load, m_wa, m_wv, ra, m_ovr};
    act = {sample_ready, tap_valid, tv ? tap_index : 8'd0, tap_first, tap_last, seq_done,
           cfg_wr_ack, cfg_wr_err, mem_load, mem_write_address, mem_write_value,
           mem_read_address, overrun};
    check(tag, act, exp);
  endtask

  // One clock: drive at negedge, advance the model, compare after the edge.
  task automatic step(input string tag, input bit sv, input bit req,
                      input logic [7:0] addr, input logic [11:0] data, input bit clr);
    bit rdy, acc, nwr, inr;
    @(negedge clk);
    sample_valid = sv; cfg_wr_req = req; cfg_wr_addr = addr;
    cfg_wr_data = data; overrun_clr = clr;
    rdy = (m_since >= N + 2) && !m_wr;
    acc = sv && rdy;
    nwr = req && !sv && rdy;
    inr = addr < N;
    m_ovr = (sv && !rdy) || (m_ovr && !clr);
    m_since = acc ? 1 : (m_since < N + 2 ? m_since + 1 : m_since);
    m_wr = nwr; m_err = nwr && !inr; m_load = nwr && inr;
    if (m_load) begin m_wa = addr; m_wv = data; end
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    sample_valid = 0; cfg_wr_req = 0; cfg_wr_addr = '0; cfg_wr_data = '0; overrun_clr = 0;
  endtask

  task automatic sync_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0; model_reset();
  endtask

  // Reset asserted mid-cycle must clear outputs with no clock edge.
  task automatic async_reset_check(input string tag);
    @(negedge clk); #2 rst = 1; #1;
    check(tag, {sample_ready, tap_valid, tap_index, tap_first, tap_last, seq_done,
                cfg_wr_ack, cfg_wr_err, mem_load, mem_write_address, mem_write_value,
                mem_read_address, overrun}, {1'b1, 44'd0});
    idle_inputs();
    @(negedge clk); rst = 0; model_reset();
  endtask

  initial begin
    bit req_r, got_ack;
    logic [7:0] a_r;
    logic [11:0] d_r;
    int ntv, k_done, k_ack, k_ovr;

    tbl[0]  = '{0,1,8'd5, 12'hABC,0, 0,1,0,1, 8'd5, 12'hABC,0,0};
    tbl[1]  = '{0,0,8'd0, 12'h000,0, 1,0,0,0, 8'd5, 12'hABC,0,0};
    tbl[2]  = '{0,1,8'd40,12'h123,0, 0,1,1,0, 8'd5, 12'hABC,0,0};
    tbl[3]  = '{0,0,8'd0, 12'h000,0, 1,0,0,0, 8'd5, 12'hABC,0,0};
    tbl[4]  = '{0,1,8'd31,12'hFFF,0, 0,1,0,1, 8'd31,12'hFFF,0,0};
    tbl[5]  = '{1,0,8'd0, 12'h000,0, 1,0,0,0, 8'd31,12'hFFF,0,1};
    tbl[6]  = '{0,1,8'd32,12'h001,1, 0,1,1,0, 8'd31,12'hFFF,0,0};
    tbl[7]  = '{1,0,8'd0, 12'h000,1, 1,0,0,0, 8'd31,12'hFFF,0,1};
    tbl[8]  = '{0,0,8'd0, 12'h000,1, 1,0,0,0, 8'd31,12'hFFF,0,0};
    tbl[9]  = '{1,0,8'd0, 12'h000,0, 0,0,0,0, 8'd31,12'hFFF,1,0};
    tbl[10] = '{0,0,8'd0, 12'h000,0, 0,0,0,0, 8'd31,12'hFFF,1,0};

    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("reset_state", {sample_ready, tap_valid, tap_index, tap_first, tap_last, seq_done,
                          cfg_wr_ack, cfg_wr_err, mem_load, mem_write_address, mem_write_value,
                          mem_read_address, overrun}, {1'b1, 44'd0});

    // Directed table: writes, range errors, overrun set/clear priority.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      sample_valid = tbl[i].sv; cfg_wr_req = tbl[i].req; cfg_wr_addr = tbl[i].addr;
      cfg_wr_data = tbl[i].data; overrun_clr = tbl[i].clr;
      @(posedge clk); #1;
      check($sformatf("table[%0d]", i),
            {8'd0, sample_ready, cfg_wr_ack, cfg_wr_err, mem_load, mem_write_address,
             mem_write_value, tap_valid, overrun, 13'd0},
            {8'd0, tbl[i].e_ready, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_load, tbl[i].e_wa,
             tbl[i].e_wv, tbl[i].e_tv, tbl[i].e_ovr, 13'd0});
    end

    // Sample and write in the same IDLE cycle, plus a dropped sample mid-run.
    sync_reset();
    step("accept_with_req", 1, 1, 8'd7, 12'h055, 0);
    ntv = (tap_valid === 1'b1) ? 1 : 0;
    k_done = 0; k_ack = 0; k_ovr = 0;
    req_r = 1;
    for (int k = 2; k <= 40; k++) begin
      step($sformatf("run_k%0d", k), k == 11, req_r, 8'd7, 12'h055, 0);
      if (tap_valid === 1'b1) ntv++;
      if (seq_done === 1'b1 && k_done == 0) k_done = k;
      if (cfg_wr_ack === 1'b1 && k_ack == 0) begin k_ack = k; req_r = 0; end
      if (overrun === 1'b1 && k_ovr == 0) k_ovr = k;
    end
    check("tap_count", 45'(ntv), 45'(N));
    check("seq_done_latency", 45'(k_done), 45'(N + 1));
    check("ack_latency", 45'(k_ack), 45'(N + 3));
    check("overrun_latency", 45'(k_ovr), 45'd11);
    step("overrun_clr", 0, 0, 8'd0, 12'h0, 1);

    // Reset mid-RUN, then mid-WRITE.
    step("pre_rst_run", 1, 0, 8'd0, 12'h0, 0);
    repeat (5) step("pre_rst_run2", 0, 0, 8'd0, 12'h0, 0);
    async_reset_check("async_rst_run");
    step("pre_rst_wr", 0, 1, 8'd3, 12'h3C3, 0);
    async_reset_check("async_rst_write");

    // Random traffic; requester holds req until ack and drops it the next cycle.
    req_r = 0; a_r = '0; d_r = '0; got_ack = 0;
    for (int i = 0; i < 3000; i++) begin
      if (req_r && got_ack) req_r = 0;
      else if (!req_r && ($urandom % 4 == 0)) begin
        req_r = 1;
        a_r = 8'($urandom_range(0, 40));
        d_r = 12'($urandom);
      end
      step("random", ($urandom % 6) == 0, req_r, a_r, d_r, ($urandom % 8) == 0);
      got_ack = (cfg_wr_ack === 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
